// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the per-thread register file: zeroes every entry after reset
// or on request, then shares the write port between pipeline writeback and host writes.
module regfile_write_arbiter #(
    parameter int NUM_THREADS = 16,
    parameter int DWIDTH      = 32,
    localparam int TW         = $clog2(NUM_THREADS),
    localparam int RF_SIZE    = NUM_THREADS * 32,
    localparam int CW         = $clog2(RF_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear_start,
    input  logic              i_wb_en,
    input  logic [TW-1:0]     i_wb_thread,
    input  logic [4:0]        i_wb_addr,
    input  logic [DWIDTH-1:0] i_wb_data,
    input  logic              i_host_req,
    input  logic [TW-1:0]     i_host_thread,
    input  logic [4:0]        i_host_addr,
    input  logic [DWIDTH-1:0] i_host_data,
    output logic              o_host_ack,
    output logic [TW-1:0]     o_rf_thread,
    output logic [4:0]        o_rf_addr,
    output logic [DWIDTH-1:0] o_rf_data,
    output logic              o_rf_wr_en,
    output logic              o_init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     c_reg, c_next;
    logic [TW-1:0]     rf_thread_reg, rf_thread_next;
    logic [4:0]        rf_addr_reg, rf_addr_next;
    logic [DWIDTH-1:0] rf_data_reg, rf_data_next;
    logic              rf_wr_en_reg, rf_wr_en_next;
    logic              host_ack_reg, host_ack_next;
    logic              init_done_reg, init_done_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= CLEAR;
            c_reg         <= '0;
            rf_thread_reg <= '0;
            rf_addr_reg   <= '0;
            rf_data_reg   <= '0;
            rf_wr_en_reg  <= 1'b0;
            host_ack_reg  <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            c_reg         <= c_next;
            rf_thread_reg <= rf_thread_next;
            rf_addr_reg   <= rf_addr_next;
            rf_data_reg   <= rf_data_next;
            rf_wr_en_reg  <= rf_wr_en_next;
            host_ack_reg  <= host_ack_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        c_next         = c_reg;
        rf_thread_next = rf_thread_reg;
        rf_addr_next   = rf_addr_reg;
        rf_data_next   = rf_data_reg;
        rf_wr_en_next  = 1'b0;
        host_ack_next  = 1'b0;
        init_done_next = 1'b0;

        case (state_reg)
            CLEAR: begin
                // The counter is the flat {thread, register} index of the entry being zeroed.
                rf_thread_next = c_reg[CW-1:5];
                rf_addr_next   = c_reg[4:0];
                rf_data_next   = '0;
                rf_wr_en_next  = 1'b1;
                if (c_reg == CW'(RF_SIZE - 1)) begin
                    state_next = RUN;
                    c_next     = '0;
                end else begin
                    c_next = c_reg + CW'(1);
                end
            end
            RUN: begin
                if (i_clear_start) begin
                    state_next = CLEAR;
                    c_next     = '0;
                end else begin
                    init_done_next = 1'b1;
                    if (i_wb_en && (i_wb_addr != 5'd0)) begin
                        rf_thread_next = i_wb_thread;
                        rf_addr_next   = i_wb_addr;
                        rf_data_next   = i_wb_data;
                        rf_wr_en_next  = 1'b1;
                    end else if (i_host_req && !host_ack_reg) begin
                        // A request still held during its ack cycle must not be granted twice.
                        host_ack_next = 1'b1;
                        if (i_host_addr != 5'd0) begin
                            rf_thread_next = i_host_thread;
                            rf_addr_next   = i_host_addr;
                            rf_data_next   = i_host_data;
                            rf_wr_en_next  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = CLEAR;
                c_next     = '0;
            end
        endcase
    end

    assign o_rf_thread = rf_thread_reg;
    assign o_rf_addr   = rf_addr_reg;
    assign o_rf_data   = rf_data_reg;
    assign o_rf_wr_en  = rf_wr_en_reg;
    assign o_host_ack  = host_ack_reg;
    assign o_init_done = init_done_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with 4 threads (128 entries): clear sequences, a vector
// table of run-time arbitration cases through a scoreboard queue, and a BRAM model.
module tb_regfile_write_arbiter;

    localparam int NT = 4;
    localparam int DW = 32;
    localparam int RF = NT * 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_clear_start;
    logic          i_wb_en;
    logic [1:0]    i_wb_thread;
    logic [4:0]    i_wb_addr;
    logic [DW-1:0] i_wb_data;
    logic          i_host_req;
    logic [1:0]    i_host_thread;
    logic [4:0]    i_host_addr;
    logic [DW-1:0] i_host_data;
    logic          o_host_ack;
    logic [1:0]    o_rf_thread;
    logic [4:0]    o_rf_addr;
    logic [DW-1:0] o_rf_data;
    logic          o_rf_wr_en;
    logic          o_init_done;

    regfile_write_arbiter #(.NUM_THREADS(NT), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .i_clear_start(i_clear_start),
        .i_wb_en(i_wb_en), .i_wb_thread(i_wb_thread), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_host_req(i_host_req), .i_host_thread(i_host_thread), .i_host_addr(i_host_addr),
        .i_host_data(i_host_data), .o_host_ack(o_host_ack), .o_rf_thread(o_rf_thread),
        .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data), .o_rf_wr_en(o_rf_wr_en),
        .o_init_done(o_init_done)
    );

    always #5 clk = ~clk;

    // Register-file model: a write presented after edge N lands on edge N+1.
    logic [DW-1:0] mem [RF];
    logic          bram_fill;
    always @(posedge clk) begin
        if (bram_fill) begin
            for (int i = 0; i < RF; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (o_rf_wr_en) begin
            mem[{o_rf_thread, o_rf_addr}] <= o_rf_data;
        end
    end

    typedef struct {
        logic        wb_en;
        logic [1:0]  wb_thread;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        host_req;
        logic [1:0]  host_thread;
        logic [4:0]  host_addr;
        logic [31:0] host_data;
        logic        exp_wr_en;
        logic        exp_ack;
        logic [1:0]  exp_thread;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          idx;
        logic        wr_en;
        logic        ack;
        logic [1:0]  thread;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    vec_t vecs [15];
    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_clear_start = 1'b0;
        i_wb_en = 1'b0; i_wb_thread = '0; i_wb_addr = '0; i_wb_data = '0;
        i_host_req = 1'b0; i_host_thread = '0; i_host_addr = '0; i_host_data = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(o_rf_wr_en), 32'd0);
        chk({tag, "_ack"}, 32'(o_host_ack), 32'd0);
        chk({tag, "_init"}, 32'(o_init_done), 32'd0);
        chk({tag, "_idx"}, 32'({o_rf_thread, o_rf_addr}), 32'd0);
        chk({tag, "_data"}, o_rf_data, 32'd0);
    endtask

    // Checks n consecutive clear writes for entries 0..n-1.
    task automatic check_clear(input string tag, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk({tag, "_wr_en"}, 32'(o_rf_wr_en), 32'd1);
            chk({tag, "_idx"}, 32'({o_rf_thread, o_rf_addr}), 32'(k));
            chk({tag, "_data"}, o_rf_data, 32'd0);
            chk({tag, "_init"}, 32'(o_init_done), 32'd0);
            chk({tag, "_ack"}, 32'(o_host_ack), 32'd0);
        end
        $display("clear %s: %0d entries presented", tag, n);
    endtask

    task automatic check_bram_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < RF; i++) if (mem[i] !== 32'd0) bad++;
        chk({tag, "_bram_nonzero"}, 32'(bad), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        bram_fill = 1'b1;

        // 1. Reset values, then the full clear from entry 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bram_fill = 1'b0;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        check_clear("clr1", RF);
        @(posedge clk); #1;
        chk("clr1_done_init", 32'(o_init_done), 32'd1);
        chk("clr1_done_wr_en", 32'(o_rf_wr_en), 32'd0);
        check_bram_zero("clr1");

        // 2-4. Run-time arbitration vectors.
        vecs[0]  = '{1'b1, 2'd2, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd2, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b1, 2'd0, 5'd1,  32'h11,       1'b1, 2'd1, 5'd7, 32'h12345678, 1'b1, 1'b0, 2'd0, 5'd1,  32'h11};
        vecs[2]  = '{1'b1, 2'd1, 5'd2,  32'h22,       1'b1, 2'd1, 5'd7, 32'h12345678, 1'b1, 1'b0, 2'd1, 5'd2,  32'h22};
        vecs[3]  = '{1'b1, 2'd3, 5'd31, 32'h33,       1'b1, 2'd1, 5'd7, 32'h12345678, 1'b1, 1'b0, 2'd3, 5'd31, 32'h33};
        vecs[4]  = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b1, 2'd1, 5'd7, 32'h12345678, 1'b1, 1'b1, 2'd1, 5'd7,  32'h12345678};
        vecs[5]  = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b1, 2'd1, 5'd7, 32'h12345678, 1'b0, 1'b0, 2'd0, 5'd0,  32'h0};
        vecs[6]  = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b0, 2'd0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 5'd0,  32'h0};
        vecs[7]  = '{1'b1, 2'd0, 5'd0,  32'hAAAA,     1'b1, 2'd2, 5'd3, 32'h55,       1'b1, 1'b1, 2'd2, 5'd3,  32'h55};
        vecs[8]  = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b0, 2'd0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 5'd0,  32'h0};
        vecs[9]  = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b1, 2'd1, 5'd0, 32'h99,       1'b0, 1'b1, 2'd0, 5'd0,  32'h0};
        vecs[10] = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b0, 2'd0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 5'd0,  32'h0};
        vecs[11] = '{1'b1, 2'd3, 5'd0,  32'h1234,     1'b0, 2'd0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 5'd0,  32'h0};
        vecs[12] = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b1, 2'd0, 5'd4, 32'hCAFE,     1'b1, 1'b1, 2'd0, 5'd4,  32'hCAFE};
        vecs[13] = '{1'b1, 2'd2, 5'd6,  32'hBEEF,     1'b1, 2'd0, 5'd4, 32'hCAFE,     1'b1, 1'b0, 2'd2, 5'd6,  32'hBEEF};
        vecs[14] = '{1'b0, 2'd0, 5'd0,  32'h0,        1'b0, 2'd0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 5'd0,  32'h0};

        for (int i = 0; i < 15; i++) begin
            exp_t e;
            @(negedge clk);
            i_wb_en = vecs[i].wb_en; i_wb_thread = vecs[i].wb_thread;
            i_wb_addr = vecs[i].wb_addr; i_wb_data = vecs[i].wb_data;
            i_host_req = vecs[i].host_req; i_host_thread = vecs[i].host_thread;
            i_host_addr = vecs[i].host_addr; i_host_data = vecs[i].host_data;
            sb_q.push_back('{i, vecs[i].exp_wr_en, vecs[i].exp_ack, vecs[i].exp_thread,
                             vecs[i].exp_addr, vecs[i].exp_data});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_wr_en", e.idx), 32'(o_rf_wr_en), 32'(e.wr_en));
            chk($sformatf("vec%0d_ack", e.idx), 32'(o_host_ack), 32'(e.ack));
            chk($sformatf("vec%0d_init", e.idx), 32'(o_init_done), 32'd1);
            if (e.wr_en) begin
                chk($sformatf("vec%0d_idx", e.idx), 32'({o_rf_thread, o_rf_addr}), 32'({e.thread, e.addr}));
                chk($sformatf("vec%0d_data", e.idx), o_rf_data, e.data);
            end
            $display("vec %0d: wr_en=%0b ack=%0b t=%0d a=%0d d=%h", e.idx, o_rf_wr_en, o_host_ack,
                     o_rf_thread, o_rf_addr, o_rf_data);
        end
        chk("hold_idx", 32'({o_rf_thread, o_rf_addr}), 32'({2'd2, 5'd6}));
        chk("hold_data", o_rf_data, 32'hBEEF);
        chk("bram_wb", mem[{2'd2, 5'd5}], 32'hDEADBEEF);
        chk("bram_host", mem[{2'd1, 5'd7}], 32'h12345678);
        chk("bram_host2", mem[{2'd2, 5'd3}], 32'h55);
        chk("bram_x0_t0", mem[{2'd0, 5'd0}], 32'd0);
        chk("bram_x0_t1", mem[{2'd1, 5'd0}], 32'd0);
        chk("bram_x0_t3", mem[{2'd3, 5'd0}], 32'd0);

        // 5. Clear request with a pending host write and a colliding writeback.
        @(negedge clk);
        i_clear_start = 1'b1;
        i_wb_en = 1'b1; i_wb_thread = 2'd1; i_wb_addr = 5'd8; i_wb_data = 32'h88;
        i_host_req = 1'b1; i_host_thread = 2'd3; i_host_addr = 5'd9; i_host_data = 32'h77;
        @(posedge clk); #1;
        chk("cs_init", 32'(o_init_done), 32'd0);
        chk("cs_wr_en", 32'(o_rf_wr_en), 32'd0);
        chk("cs_ack", 32'(o_host_ack), 32'd0);
        @(negedge clk);
        i_clear_start = 1'b0;
        i_wb_en = 1'b0;
        check_clear("clr2", RF);
        @(posedge clk); #1;
        chk("clr2_init", 32'(o_init_done), 32'd1);
        chk("clr2_ack", 32'(o_host_ack), 32'd1);
        chk("clr2_wr_en", 32'(o_rf_wr_en), 32'd1);
        chk("clr2_idx", 32'({o_rf_thread, o_rf_addr}), 32'({2'd3, 5'd9}));
        chk("clr2_data", o_rf_data, 32'h77);
        check_bram_zero("clr2");
        @(negedge clk);
        i_host_req = 1'b0;
        @(posedge clk); #1;
        chk("clr2_ack_drop", 32'(o_host_ack), 32'd0);
        chk("clr2_bram_host", mem[{2'd3, 5'd9}], 32'h77);

        // 6. Reset during a clear, after 60 entries.
        @(negedge clk);
        i_clear_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        i_clear_start = 1'b0;
        check_clear("clr3", 60);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_rst");
        @(posedge clk); #1;
        check_outputs_zero("rst_held");
        @(negedge clk);
        reset = 1'b0;
        check_clear("clr4", RF);
        @(posedge clk); #1;
        chk("clr4_init", 32'(o_init_done), 32'd1);
        chk("clr4_wr_en", 32'(o_rf_wr_en), 32'd0);
        check_bram_zero("clr4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
